// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the three-channel RGB PWM generator.
package rgb_pwm_pkg;

    // Default duty / PWM counter resolution in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Channel selectors on the write port.
    localparam logic [1:0] CHAN_R   = 2'd0;
    localparam logic [1:0] CHAN_G   = 2'd1;
    localparam logic [1:0] CHAN_B   = 2'd2;
    localparam logic [1:0] CHAN_ALL = 2'd3;

    // Duty value at the default resolution.
    typedef logic [DEFAULT_WIDTH-1:0] duty_t;

    // True when a write addressed to 'sel' targets channel 'idx'.
    function automatic logic chan_hit(input logic [1:0] sel, input logic [1:0] idx);
        return (sel == idx) || (sel == CHAN_ALL);
    endfunction

endpackage

// File: rtl/rgb_pwm_gen_channel.sv
// One PWM channel: holds the host target and the duty actually in use,
// moves the active duty only at period boundaries, and drives a registered
// compare output aligned with the shared counter.
module pwm_fade_channel
    import rgb_pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_duty_i,
    input  logic             pb_i,
    input  logic             fade_step_i,
    input  logic             fade_en_i,
    input  logic [WIDTH-1:0] cnt_next_i,
    output logic             pwm_o,
    output logic             mismatch_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q,    pwm_d;

    // Move 'cur' one LSB toward 'tgt'; equal values stay put.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] res;
        if (cur < tgt) begin
            res = cur + ONE;
        end else if (cur > tgt) begin
            res = cur - ONE;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Target register: latest accepted write wins, no queueing.
    always_comb begin
        target_d = target_q;
        if (wr_en_i) begin
            target_d = wr_duty_i;
        end else begin
            target_d = target_q;
        end
    end

    // Active duty changes only on a period boundary, using the pre-write target.
    always_comb begin
        active_d = active_q;
        if (pb_i) begin
            if (!fade_en_i) begin
                active_d = target_q;
            end else if (fade_step_i) begin
                active_d = step_toward(active_q, target_q);
            end else begin
                active_d = active_q;
            end
        end else begin
            active_d = active_q;
        end
    end

    // Compare against next-cycle counter/duty so the registered output lines up
    // with the counter value it represents (new duty shows from cnt=0).
    always_comb begin
        pwm_d = (cnt_next_i < active_d);
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            target_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o      = pwm_q;
    assign mismatch_o = (active_q != target_q);

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB LED PWM generator. Owns the shared prescaler, PWM
// counter, fade-step counter, write decode, busy and period_start; the
// per-channel target/active duties live in pwm_fade_channel.
module rgb_pwm_gen
    import rgb_pwm_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int PRESCALE     = 188,
    parameter int FADE_PERIODS = 4
) (
    input  logic             clkin,
    input  logic             resetn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_chan,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             fade_en,
    output logic [2:0]       pwm,
    output logic             period_start,
    output logic             busy
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FC_W  = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FADE_PERIODS - 1);
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);

    logic [PRE_W-1:0] pre_q,  pre_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             wr_ready_q, wr_ready_d;
    logic             period_start_q, period_start_d;
    logic             busy_q, busy_d;

    logic             tick_s;
    logic             pb_s;
    logic             fade_step_s;
    logic             wr_fire_s;
    logic [2:0]       wr_en_s;
    logic [2:0]       pwm_s;
    logic [2:0]       mismatch_s;

    // Shared timing strobes: prescaler tick, period boundary, fade step.
    always_comb begin
        tick_s      = (pre_q == PRE_LAST);
        pb_s        = tick_s && (cnt_q == CNT_LAST);
        fade_step_s = pb_s && fade_en && (fcnt_q == FC_LAST);
    end

    // Prescaler and PWM counter next state; cnt wraps naturally at 2^WIDTH.
    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (tick_s) begin
            pre_d = '0;
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            pre_d = pre_q + PRE_ONE;
            cnt_d = cnt_q;
        end
    end

    // Fade period counter advances only on boundaries with fading enabled.
    always_comb begin
        fcnt_d = fcnt_q;
        if (pb_s && fade_en) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + FC_ONE;
            end
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Write decode: broadcast selector hits every channel.
    always_comb begin
        wr_fire_s = wr_valid && wr_ready_q;
        wr_en_s   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            wr_en_s[i] = wr_fire_s && chan_hit(wr_chan, i[1:0]);
        end
    end

    // Status next state: ready after reset, boundary pulse, any-channel mismatch.
    always_comb begin
        wr_ready_d     = 1'b1;
        period_start_d = pb_s;
        busy_d         = |mismatch_s;
    end

    // Shared state registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            fcnt_q         <= '0;
            wr_ready_q     <= 1'b0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            fcnt_q         <= fcnt_d;
            wr_ready_q     <= wr_ready_d;
            period_start_q <= period_start_d;
            busy_q         <= busy_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        pwm_fade_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i       (clkin),
            .rst_n_i     (resetn),
            .wr_en_i     (wr_en_s[gi]),
            .wr_duty_i   (wr_duty),
            .pb_i        (pb_s),
            .fade_step_i (fade_step_s),
            .fade_en_i   (fade_en),
            .cnt_next_i  (cnt_d),
            .pwm_o       (pwm_s[gi]),
            .mismatch_o  (mismatch_s[gi])
        );
    end

    assign wr_ready     = wr_ready_q;
    assign period_start = period_start_q;
    assign busy         = busy_q;
    assign pwm          = pwm_s;

endmodule
